// File: rtl/apb_intc.sv
// APB interrupt controller: pending latch, enable mask, lowest-index arbitration, claim/complete.
// Build option INTC_EDGE_TRIG_EN switches the gateway from level to rising-edge capture.
module apb_intc #(
   parameter int NUM_SRC = 40,
   parameter int ID_W    = 6
) (
   input  logic               pclk,
   input  logic               prst,
   input  logic               psel,
   input  logic               penable,
   input  logic               pwrite,
   input  logic [4:0]         paddr,
   input  logic [31:0]        pwdata,
   output logic [31:0]        prdata,
   input  logic [NUM_SRC-1:0] xx_intc_vld,
   output logic               intc_int_req
);

   localparam logic [4:0] A_IER_LO = 5'd0;
   localparam logic [4:0] A_IER_HI = 5'd1;
   localparam logic [4:0] A_IPR_LO = 5'd2;
   localparam logic [4:0] A_IPR_HI = 5'd3;
   localparam logic [4:0] A_CLAIM  = 5'd4;
   localparam logic [4:0] A_STATUS = 5'd5;
   localparam logic [4:0] A_SRC_D  = 5'd6;

   logic [NUM_SRC-1:0] ier;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clr_vec;
   logic [NUM_SRC-1:0] pending_next;
   logic               active_vld;
   logic [ID_W-1:0]    active_id;
   logic [ID_W-1:0]    win_id;
   logic               win_vld;
   logic               access;
   logic               claim;
   logic               complete;
   logic [63:0]        ier_ext;
   logic [63:0]        pend_ext;
   logic [31:0]        claim_val;
   logic [31:0]        status_val;

   assign access   = psel & penable;
   assign eligible = pending & ier;
   assign ier_ext  = 64'(ier);
   assign pend_ext = 64'(pending);

   // Lowest index wins: scan downward so the last hit is the smallest index.
   always_comb begin
      win_vld = |eligible;
      win_id  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) win_id = ID_W'(i);
      end
   end

   assign claim    = access & ~pwrite & (paddr == A_CLAIM) & ~active_vld & win_vld;
   assign complete = access & pwrite & (paddr == A_CLAIM) & active_vld
                     & (pwdata[ID_W-1:0] == active_id + ID_W'(1));
   assign clr_vec  = claim ? (NUM_SRC'(1) << win_id) : '0;

`ifdef INTC_EDGE_TRIG_EN
   logic [NUM_SRC-1:0] src_d;

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) src_d <= '0;
      else      src_d <= xx_intc_vld;
   end

   // Set after clear so an edge arriving on the claim cycle is never dropped.
   assign pending_next = (pending & ~clr_vec) | (xx_intc_vld & ~src_d);
`else
   logic [NUM_SRC-1:0] act_vec;

   // The source being serviced cannot re-pend until it has been completed.
   assign act_vec      = active_vld ? (NUM_SRC'(1) << active_id) : '0;
   assign pending_next = (pending | (xx_intc_vld & ~act_vec)) & ~clr_vec;
`endif

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         ier          <= '0;
         pending      <= '0;
         active_vld   <= 1'b0;
         active_id    <= '0;
         intc_int_req <= 1'b0;
      end else begin
         pending      <= pending_next;
         intc_int_req <= (|eligible) & ~active_vld;
         if (access && pwrite && paddr == A_IER_LO) ier <= NUM_SRC'({ier_ext[63:32], pwdata});
         if (access && pwrite && paddr == A_IER_HI) ier <= NUM_SRC'({pwdata, ier_ext[31:0]});
         if (claim) begin
            active_vld <= 1'b1;
            active_id  <= win_id;
         end else if (complete) begin
            active_vld <= 1'b0;
         end
      end
   end

   assign claim_val  = (win_vld && !active_vld) ? 32'(win_id) + 32'd1 : 32'd0;
   assign status_val = active_vld ? (32'h8000_0000 | (32'(active_id) + 32'd1)) : 32'd0;

   always_comb begin
      prdata = 32'd0;
      if (psel) begin
         case (paddr)
            A_IER_LO: prdata = ier_ext[31:0];
            A_IER_HI: prdata = ier_ext[63:32];
            A_IPR_LO: prdata = pend_ext[31:0];
            A_IPR_HI: prdata = pend_ext[63:32];
            A_CLAIM:  prdata = claim_val;
            A_STATUS: prdata = status_val;
`ifdef INTC_EDGE_TRIG_EN
            A_SRC_D:  prdata = 32'(64'(src_d));
`else
            A_SRC_D:  prdata = 32'd0;
`endif
            default:  prdata = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_intc.sv
// Bench for apb_intc: directed scenarios then random traffic, all checked against
// a cycle-level reference model built from the register and gateway rules.
module tb_apb_intc;
   localparam int NUM_SRC = 40;
   localparam int ID_W    = 6;
   localparam logic [63:0] SRC_MASK = (64'd1 << NUM_SRC) - 64'd1;

   logic               pclk = 1'b0;
   logic               prst = 1'b1;
   logic               psel = 1'b0;
   logic               penable = 1'b0;
   logic               pwrite = 1'b0;
   logic [4:0]         paddr = '0;
   logic [31:0]        pwdata = '0;
   logic [31:0]        prdata;
   logic [NUM_SRC-1:0] src = '0;
   logic               intc_int_req;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [63:0] ier_m, pend_m, srcp_m;
   logic        active_m;
   int          aid_m;
   logic        req_m;

   always #5 pclk = ~pclk;

   apb_intc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
      .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .xx_intc_vld(src), .intc_int_req(intc_int_req)
   );

   function automatic int winner();
      for (int i = 0; i < NUM_SRC; i++) if (pend_m[i] && ier_m[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      int w;
      w = winner();
      case (a)
         5'd0: return ier_m[31:0];
         5'd1: return ier_m[63:32];
         5'd2: return pend_m[31:0];
         5'd3: return pend_m[63:32];
         5'd4: return (!active_m && w >= 0) ? 32'(w + 1) : 32'd0;
         5'd5: return active_m ? (32'h8000_0000 | 32'(aid_m + 1)) : 32'd0;
`ifdef INTC_EDGE_TRIG_EN
         5'd6: return srcp_m[31:0];
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ier_m = '0; pend_m = '0; srcp_m = '0; active_m = 1'b0; aid_m = 0; req_m = 1'b0;
   endtask

   // One clock: predict next state from the inputs the DUT sees, then check outputs.
   task automatic cycle();
      logic [63:0] ier_n, pend_n, s;
      logic act_n, req_n, acc, claim, comp;
      int aid_n, w;
      s = 64'(src);
      w = winner();
      acc = psel && penable;
      claim = acc && !pwrite && paddr == 5'd4 && !active_m && w >= 0;
      comp = acc && pwrite && paddr == 5'd4 && active_m && int'(pwdata[ID_W-1:0]) == aid_m + 1;
      ier_n = ier_m; pend_n = pend_m; act_n = active_m; aid_n = aid_m;
      req_n = (w >= 0) && !active_m;
      for (int i = 0; i < NUM_SRC; i++) begin
`ifdef INTC_EDGE_TRIG_EN
         pend_n[i] = (pend_m[i] && !(claim && w == i)) || (s[i] && !srcp_m[i]);
`else
         pend_n[i] = (pend_m[i] || (s[i] && !(active_m && aid_m == i))) && !(claim && w == i);
`endif
      end
      if (acc && pwrite && paddr == 5'd0) ier_n[31:0] = pwdata;
      if (acc && pwrite && paddr == 5'd1) ier_n[63:32] = pwdata;
      ier_n &= SRC_MASK;
      if (claim) begin act_n = 1'b1; aid_n = w; end
      if (comp) act_n = 1'b0;
      @(posedge pclk);
      if (prst) model_reset();
      else begin
         ier_m = ier_n; pend_m = pend_n; active_m = act_n; aid_m = aid_n; req_m = req_n; srcp_m = s;
      end
      #1;
      chk("req", {31'd0, intc_int_req}, {31'd0, req_m});
      if (!psel) chk("prdata_idle", prdata, 32'd0);
   endtask

   task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      cycle();
      penable = 1'b1;
      #1;
      d = prdata;
      chk($sformatf("rd@%02h", 32'(a) * 4), d, exp_read(a));
      $display("apb rd  @%02h -> %08h", 32'(a) * 4, d);
      cycle();
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      cycle();
      penable = 1'b1;
      $display("apb wr  @%02h <- %08h", 32'(a) * 4, d);
      cycle();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic do_reset();
      prst = 1'b1;
      model_reset();
      cycle();
      cycle();
      prst = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int op, w;
      model_reset();

      // Reset with every source asserted.
      src = '1;
      #1;
      cycle();
      chk("rst_req", {31'd0, intc_int_req}, 32'd0);
      apb_read(5'd2, d); chk("rst_ipr_lo", d, 32'd0);
      apb_read(5'd5, d); chk("rst_status", d, 32'd0);
      prst = 1'b0;
      cycle();
      apb_read(5'd2, d); chk("post_ipr_lo", d, 32'hFFFF_FFFF);
      apb_read(5'd3, d); chk("post_ipr_hi", d, 32'h0000_00FF);
      chk("post_req", {31'd0, intc_int_req}, 32'd0);

      // Reset during an IER write access phase leaves no trace.
      src = '0;
      do_reset();
      psel = 1'b1; pwrite = 1'b1; paddr = 5'd0; pwdata = 32'hFFFF_FFFF;
      cycle();
      penable = 1'b1; prst = 1'b1; model_reset();
      cycle();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; prst = 1'b0;
      apb_read(5'd0, d); chk("rst_mid_ier", d, 32'd0);

      // Single source on bit 4.
      apb_write(5'd0, 32'h10);
      src[4] = 1'b1; cycle(); src[4] = 1'b0; cycle();
      chk("single_req", {31'd0, intc_int_req}, 32'd1);
      apb_read(5'd4, d); chk("single_claim", d, 32'd5);
      apb_read(5'd5, d); chk("single_status", d, 32'h8000_0005);
      chk("single_req_low", {31'd0, intc_int_req}, 32'd0);
      apb_write(5'd4, 32'd5);
      apb_read(5'd5, d); chk("single_done", d, 32'd0);

      // Priority among sources 0, 4 and 32, plus bad completes.
      apb_write(5'd0, 32'hFFFF_FFFF);
      apb_write(5'd1, 32'hFFFF_FFFF);
      apb_read(5'd1, d); chk("ier_hi_mask", d, 32'h0000_00FF);
      src = '0; src[0] = 1'b1; src[4] = 1'b1; src[32] = 1'b1;
      cycle(); src = '0; cycle();
      apb_read(5'd4, d); chk("prio_1", d, 32'd1);
      apb_read(5'd4, d); chk("prio_busy", d, 32'd0);
      apb_read(5'd2, d); chk("prio_ipr", d, 32'h10);
      apb_write(5'd4, 32'd1);
      apb_read(5'd4, d); chk("prio_5", d, 32'd5);
      apb_write(5'd4, 32'd3);
      apb_write(5'd4, 32'd0);
      apb_read(5'd5, d); chk("bad_complete", d, 32'h8000_0005);
      apb_write(5'd4, 32'd5);
      apb_read(5'd5, d); chk("good_complete", d, 32'd0);
      apb_read(5'd4, d); chk("prio_33", d, 32'd33);
      apb_write(5'd4, 32'd33);

`ifdef INTC_EDGE_TRIG_EN
      // Edges while active and on the claim cycle are both retained.
      src[4] = 1'b1; cycle(); src[4] = 1'b0; cycle();
      apb_read(5'd4, d); chk("edge_claim", d, 32'd5);
      src[4] = 1'b1; cycle(); src[4] = 1'b0; cycle();
      apb_write(5'd4, 32'd5);
      psel = 1'b1; pwrite = 1'b0; paddr = 5'd4;
      cycle();
      penable = 1'b1; src[4] = 1'b1;
      cycle();
      psel = 1'b0; penable = 1'b0;
      apb_read(5'd2, d); chk("edge_keep", d & 32'h10, 32'h10);
      apb_write(5'd4, 32'd5);
      apb_read(5'd4, d); chk("edge_claim2", d, 32'd5);
      apb_write(5'd4, 32'd5);
      cycle(); cycle();
      apb_read(5'd2, d); chk("edge_no_repend", d, 32'd0);
      src = '0;
`else
      // Level source held through complete re-pends and re-requests.
      src[0] = 1'b1; cycle(); cycle();
      apb_read(5'd4, d); chk("rearm_claim", d, 32'd1);
      apb_write(5'd4, 32'd1);
      apb_read(5'd2, d); chk("rearm_ipr", d & 32'd1, 32'd1);
      chk("rearm_req", {31'd0, intc_int_req}, 32'd1);
      src = '0;
      apb_read(5'd4, d); chk("rearm_claim2", d, 32'd1);
      apb_write(5'd4, 32'd1);
`endif

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 6);
         case (op)
            0: begin
               src = NUM_SRC'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
               cycle();
            end
            1: apb_read(5'($urandom_range(0, 31)), d);
            2: apb_read(5'd4, d);
            3: begin
               w = (active_m && $urandom_range(0, 2) != 0) ? aid_m + 1 : $urandom_range(0, 63);
               apb_write(5'd4, 32'(w));
            end
            4: apb_write(5'($urandom_range(0, 1)), $urandom);
            5: apb_write(5'($urandom_range(2, 31)), $urandom);
            default: cycle();
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
